ahb_lite_master: RTL and testbench
==================================

# ahb_lite_master

AHB-Lite single-outstanding master bridge that turns core load/store/fetch requests into bus transfers for the RAM/ROM slave decode. It sits between the core memory port and the AHB slave side. It drives haddr/htrans/hwrite/hsize/hprot/hwdata, tracks the address and data phases, and returns read data or an error to the core as a one-cycle response pulse. Address-phase and data-phase signals are registered.

## Interface
- No parameters; data and address widths are fixed at 32.
- hclk  in  1  system clock; all state updates on the rising edge.
- hresetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_write  in  1  1 = store, 0 = load/fetch.
- req_fetch  in  1  1 = opcode fetch; copied to hprot[0].
- req_addr  in  32  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_wdata  in  32  store data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  1  qualifies rsp_valid; 1 = transfer failed.
- rsp_rdata  out  32  read data; valid with rsp_valid for a non-error read.
- haddr  out  32  AHB address.
- htrans  out  2  00 IDLE, 10 NONSEQ; no other encodings are driven.
- hwrite  out  1  AHB write.
- hsize  out  3  {1'b0, req_size}.
- hprot  out  4  {3'b000, req_fetch}.
- hwdata  out  32  write data, driven during the data phase.
- hrdata  in  32  AHB read data.
- hready  in  1  AHB transfer ready.
- hresp  in  1  AHB error response.

## Operation
- FSM states:
  - IDLE
    - req_ready = 1 (combinational from state).
    - On req_valid, latch addr/size/write/fetch/wdata, load the address-phase registers (htrans = 10), and go to ADDR.
  - ADDR
    - Address phase is on the bus.
    - Hold all address-phase outputs while hready = 0.
    - On an edge with hready = 1: htrans becomes 00, hwdata is loaded from the latched data, and the FSM goes to DATA.
  - DATA
    - Hold hwdata while hready = 0.
    - hready = 1, hresp = 0: success. Capture hrdata into rsp_rdata (reads only; writes leave rsp_rdata unchanged), pulse rsp_valid with rsp_err = 0, go to IDLE.
    - hready = 0, hresp = 1: first cycle of a standard two-cycle error; go to ERR.
    - hready = 1, hresp = 1: single-cycle error, which the slave decode produces for ROM writes and fetches. Pulse rsp_valid with rsp_err = 1, go to IDLE.
  - ERR
    - Wait for hready = 1, then pulse rsp_valid with rsp_err = 1 and go to IDLE. rsp_rdata is unchanged.
- At most one transfer is outstanding. req_ready = 0 in ADDR, DATA and ERR.
- The response pulse and IDLE coincide. A new request may be accepted in the same cycle rsp_valid is high.
- Reset, including mid-transfer, forces the following immediately; an in-flight transfer produces no response:
  - state IDLE
  - htrans = 00, haddr = 0, hwrite = 0, hsize = 0, hprot = 0, hwdata = 0
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0
  - req_ready = 1

## Timing
- Request accepted at edge E0.
- Address phase is visible in the cycle after E0.
- With zero wait states:
  - DATA after E1.
  - rsp_valid is high in the cycle after E2.
  - Request-to-response latency is 3 cycles.
- Each hready = 0 cycle adds one cycle.
- A two-cycle error response adds one cycle over the single-cycle form.
- rsp_valid is high for exactly one cycle per accepted request, unless reset intervenes.

## Configuration
- AHB_MASTER_ALIGN_CHECK_EN defined:
  - In IDLE, a request is rejected locally if it is misaligned (half with addr[0] = 1; word with addr[1:0] != 00) or has req_size = 11.
  - A rejected request is still accepted (req_ready = 1).
  - No bus transfer is issued; htrans stays 00.
  - rsp_valid = 1 with rsp_err = 1 in the next cycle.
- Undefined:
  - All requests go to the bus unchanged.
  - req_size = 11 is driven as hsize = 011.

## Test plan
- Word read, addr B000_0010, zero wait, hrdata = 1234_5678:
  - htrans = 10 for one cycle.
  - rsp_valid 3 cycles after acceptance with rsp_rdata = 1234_5678, rsp_err = 0.
- Word write to B000_0004, data DEAD_BEEF, hready low 2 cycles in the data phase:
  - hwdata = DEAD_BEEF held through the wait cycles.
  - rsp_valid at cycle 5, rsp_err = 0.
- Write to A000_0000 (ROM), slave returns hresp = 1 with hready = 1:
  - rsp_valid with rsp_err = 1; the next request is accepted in the same cycle.
- Two-cycle error response (hresp = 1/hready = 0, then hresp = 1/hready = 1):
  - FSM passes through ERR; a single rsp_err pulse.
- Fetch request with req_fetch = 1: hprot = 0001 during the address phase.
- Reset asserted in DATA: htrans = 00, req_ready = 1, no rsp_valid.
- With AHB_MASTER_ALIGN_CHECK_EN, word read at B000_0002: no NONSEQ issued; rsp_err = 1 one cycle after acceptance.

Source files
------------

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: single-outstanding AHB-Lite master bridge.
// Converts core load/store/fetch requests into one NONSEQ transfer each and
// returns a one-cycle response pulse with read data or an error flag.
// Optional build macro: AHB_MASTER_ALIGN_CHECK_EN rejects misaligned or
// reserved-size requests locally, without issuing a bus transfer.
module ahb_lite_master (
  input  logic        hclk,
  input  logic        hresetn,
  // core request side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_fetch,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  // core response side
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  // AHB-Lite master side
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [3:0]  hprot,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADDR = 2'b01,
    S_DATA = 2'b10,
    S_ERR  = 2'b11
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t      state, state_next;
  logic [31:0] wdata_q;     // store data parked until the data phase starts
  logic        misaligned;  // request would be rejected without a bus transfer
  logic        start_xfer;  // accept a request and launch its address phase
  logic        reject;      // accept a request and fail it locally
  logic        addr_done;   // address phase completes on this edge
  logic        rsp_ok;      // transfer completes successfully on this edge
  logic        rsp_bad;     // transfer completes with an error on this edge

  // Local rejection of misaligned accesses and the reserved size encoding.
`ifdef AHB_MASTER_ALIGN_CHECK_EN
  always_comb begin
    misaligned = (req_size == 2'b11) ||
                 (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  end
`else
  assign misaligned = 1'b0;
`endif

  // State register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= S_IDLE;
    end else begin
      // NOTE: non-blocking assignment for every flop so all registers update
      // from the same pre-edge values regardless of block ordering.
      state <= state_next;
    end
  end

  // Next-state decode and single-cycle control strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_next = state;
    req_ready  = 1'b0;
    start_xfer = 1'b0;
    reject     = 1'b0;
    addr_done  = 1'b0;
    rsp_ok     = 1'b0;
    rsp_bad    = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misaligned) begin
            reject = 1'b1;
          end else begin
            start_xfer = 1'b1;
            state_next = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (hready) begin
          addr_done  = 1'b1;
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (hresp) begin
          if (hready) begin
            rsp_bad    = 1'b1;
            state_next = S_IDLE;
          end else begin
            state_next = S_ERR;
          end
        end else if (hready) begin
          rsp_ok     = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_ERR: begin
        if (hready) begin
          rsp_bad    = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Registered bus outputs, parked store data and the core response.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr     <= '0;
      htrans    <= HTRANS_IDLE;
      hwrite    <= 1'b0;
      hsize     <= '0;
      hprot     <= '0;
      hwdata    <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= rsp_ok | rsp_bad | reject;
      rsp_err   <= rsp_bad | reject;
      if (start_xfer) begin
        haddr   <= req_addr;
        htrans  <= HTRANS_NONSEQ;
        hwrite  <= req_write;
        hsize   <= {1'b0, req_size};
        hprot   <= {3'b000, req_fetch};
        wdata_q <= req_wdata;
      end
      if (addr_done) begin
        htrans <= HTRANS_IDLE;
        hwdata <= wdata_q;
      end
      // hwrite still describes the completing transfer during the data phase.
      if (rsp_ok && !hwrite) begin
        rsp_rdata <= hrdata;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Testbench for ahb_lite_master: directed vector table, back-to-back
// requests, reset in the data phase, and randomized transfers compared
// against a latency/response model derived from the transfer rules.
module tb_ahb_lite_master;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        req_valid, req_ready, req_write, req_fetch;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic        hwrite, hready, hresp;
  logic [2:0]  hsize;
  logic [3:0]  hprot;

  always #5 hclk = ~hclk;

  ahb_lite_master dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_fetch (req_fetch),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hprot     (hprot),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hready    (hready),
    .hresp     (hresp)
  );

  // One transfer: request fields, slave behaviour, expected outcome.
  // em: 0 = OKAY, 1 = single-cycle error, 2 = two-cycle error.
  typedef struct {
    logic        write;
    logic        fetch;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          aw;       // hready-low cycles in the address phase
    int          dw;       // hready-low cycles in the data phase
    int          em;
    int          exp_lat;  // negedges from acceptance to rsp_valid
    logic        exp_err;
    logic        issue;    // a bus transfer is expected
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_rdata;
  vec_t        tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic fe, input logic [31:0] a,
                              input logic [1:0] sz, input logic [31:0] wd, input logic [31:0] rd,
                              input int aw, input int dw, input int em,
                              input int lat, input logic err, input logic iss);
    vec_t v;
    v.write = wr;  v.fetch = fe;  v.addr = a;   v.size = sz;
    v.wdata = wd;  v.rdata = rd;  v.aw = aw;    v.dw = dw;   v.em = em;
    v.exp_lat = lat; v.exp_err = err; v.issue = iss;
    return v;
  endfunction

  // Reference model: outcome from the transfer rules alone.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic mis;
    mis = (v.size == 2'b11) || (v.size == 2'b01 && v.addr[0]) ||
          (v.size == 2'b10 && v.addr[1:0] != 2'b00);
    r.issue   = 1'b1;
    r.exp_lat = 3 + v.aw + v.dw + ((v.em == 2) ? 1 : 0);
    r.exp_err = (v.em != 0);
`ifdef AHB_MASTER_ALIGN_CHECK_EN
    if (mis) begin
      r.issue   = 1'b0;
      r.exp_lat = 1;
      r.exp_err = 1'b1;
    end
`else
    if (mis) r.issue = 1'b1;
`endif
    return r;
  endfunction

  // Presents one request at the current negedge and plays the slave.
  task automatic run_xfer(input vec_t v);
    int   scr[$];   // per-cycle slave drive: bit2 final, bit1 hready, bit0 hresp
    int   lat    = 0;
    int   nonseq = 0;
    bit   seen   = 0;
    if (v.issue) begin
      for (int i = 0; i < v.aw; i++) scr.push_back(3'b000);
      scr.push_back(3'b010);
      for (int i = 0; i < v.dw; i++) scr.push_back(3'b000);
      if (v.em == 2) scr.push_back(3'b001);
      scr.push_back((v.em == 0) ? 3'b110 : 3'b111);
    end
    req_valid = 1'b1;
    req_write = v.write;
    req_fetch = v.fetch;
    req_addr  = v.addr;
    req_size  = v.size;
    req_wdata = v.wdata;
    #1;
    check("req_ready_idle", req_ready, 1'b1);
    for (int k = 1; k <= v.exp_lat + 4 && !seen; k++) begin
      @(negedge hclk);
      if (k == 1) begin
        req_valid = 1'b0;
        req_wdata = ~v.wdata;
        if (v.issue) begin
          check("rsp_pulse_width", rsp_valid, 1'b0);
          check("req_ready_busy", req_ready, 1'b0);
          check("haddr", haddr, v.addr);
          check("hwrite", hwrite, v.write);
          check("hsize", hsize, {1'b0, v.size});
          check("hprot", hprot, {3'b000, v.fetch});
        end
      end
      if (htrans == 2'b10) nonseq++;
      if (v.issue && v.write && k >= v.aw + 2 && k <= scr.size())
        check("hwdata_held", hwdata, v.wdata);
      if (k <= scr.size()) begin
        hready = scr[k-1][1];
        hresp  = scr[k-1][0];
        hrdata = scr[k-1][2] ? v.rdata : ~v.rdata;
      end else begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = 32'h5A5A_A5A5;
      end
      if (rsp_valid) begin
        seen = 1;
        lat  = k;
      end
    end
    if (seen && v.issue && !v.write && !v.exp_err) exp_rdata = v.rdata;
    check("latency", lat, v.exp_lat);
    check("nonseq_cycles", nonseq, v.issue ? v.aw + 1 : 0);
    check("rsp_err", rsp_err, v.exp_err);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("req_ready_on_rsp", req_ready, 1'b1);
  endtask

  task automatic idle_cycle();
    @(negedge hclk);
    check("rsp_idle", rsp_valid, 1'b0);
  endtask

  initial begin
    int npulse;
    vec_t v;
    hresetn = 1'b0;  req_valid = 1'b0;  req_write = 1'b0;  req_fetch = 1'b0;
    req_addr = '0;   req_size = '0;     req_wdata = '0;
    hready = 1'b1;   hresp = 1'b0;      hrdata = '0;
    exp_rdata = '0;

    // directed table: write, fetch, addr, size, wdata, rdata, aw, dw, em, lat, err, issue
    tbl[0] = mk(0, 0, 32'hB000_0010, 2'b10, 32'h0,         32'h1234_5678, 0, 0, 0, 3, 0, 1);
    tbl[1] = mk(1, 0, 32'hB000_0004, 2'b10, 32'hDEAD_BEEF, 32'h0,         0, 2, 0, 5, 0, 1);
    tbl[2] = mk(1, 0, 32'hA000_0000, 2'b10, 32'h0BAD_0001, 32'h0,         0, 0, 1, 3, 1, 1);
    tbl[3] = mk(0, 0, 32'hB000_0020, 2'b10, 32'h0,         32'h7777_0000, 0, 0, 2, 4, 1, 1);
    tbl[4] = mk(0, 1, 32'hB000_0100, 2'b10, 32'h0,         32'hCAFE_F00D, 0, 0, 0, 3, 0, 1);
    tbl[5] = mk(0, 0, 32'hB000_0042, 2'b01, 32'h0,         32'h0000_BEEF, 1, 1, 0, 5, 0, 1);
`ifdef AHB_MASTER_ALIGN_CHECK_EN
    tbl[6] = mk(0, 0, 32'hB000_0002, 2'b10, 32'h0,         32'h0BAD_CAFE, 0, 0, 0, 1, 1, 0);
    tbl[7] = mk(1, 0, 32'hB000_0008, 2'b11, 32'h1357_9BDF, 32'h0,         0, 0, 0, 1, 1, 0);
`else
    tbl[6] = mk(0, 0, 32'hB000_0002, 2'b10, 32'h0,         32'h0BAD_CAFE, 0, 0, 0, 3, 0, 1);
    tbl[7] = mk(1, 0, 32'hB000_0008, 2'b11, 32'h1357_9BDF, 32'h0,         0, 0, 0, 3, 0, 1);
`endif

    // reset state
    #12;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_htrans", htrans, 2'b00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge hclk);
    hresetn = 1'b1;
    idle_cycle();

    // directed table; odd entries are followed by an idle cycle, even ones
    // chain straight into the next request in the response cycle
    for (int i = 0; i < 8; i++) begin
      run_xfer(tbl[i]);
      if (i % 2 == 1) idle_cycle();
    end

    // reset asserted while the data phase is waiting
    req_valid = 1'b1;  req_write = 1'b1;  req_fetch = 1'b0;
    req_addr = 32'hB000_0008;  req_size = 2'b10;  req_wdata = 32'h1111_2222;
    @(negedge hclk);
    req_valid = 1'b0;  hready = 1'b1;
    @(negedge hclk);
    hready = 1'b0;
    check("pre_rst_hwdata", hwdata, 32'h1111_2222);
    #2 hresetn = 1'b0;
    #1;
    check("mid_rst_htrans", htrans, 2'b00);
    check("mid_rst_req_ready", req_ready, 1'b1);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_haddr", haddr, 32'h0);
    check("mid_rst_hwdata", hwdata, 32'h0);
    check("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
    exp_rdata = '0;
    @(negedge hclk);
    hresetn = 1'b1;  hready = 1'b1;
    npulse = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge hclk);
      if (rsp_valid) npulse++;
    end
    check("no_rsp_after_rst", npulse, 0);

    // randomized transfers against the model
    for (int n = 0; n < 60; n++) begin
      v.write = 1'($urandom_range(0, 1));
      v.fetch = v.write ? 1'b0 : 1'($urandom_range(0, 1));
      v.size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      v.addr  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (v.size == 2'b01) v.addr[0] = 1'b0;
        if (v.size == 2'b10) v.addr[1:0] = 2'b00;
      end
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.aw    = $urandom_range(0, 2);
      v.dw    = $urandom_range(0, 3);
      v.em    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      v = model(v);
      run_xfer(v);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
